// File: rtl/avl_switch_accum_pkg.sv
// Shared constants and types for the switch accumulator peripheral and its key debouncer.
package avl_switch_accum_pkg;

    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BE_W    = DATA_W / 8;
    localparam int unsigned SW_W    = 8;
    localparam int unsigned COUNT_W = 8;
    localparam int unsigned CTRL_W  = 2;
    localparam int unsigned STAT_W  = 2;

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_ACC    = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_COUNT  = 2'd3;

    localparam int unsigned CTRL_ACC_EN = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned STATUS_OVF  = 0;
    localparam int unsigned STATUS_PEND = 1;

    localparam logic [CTRL_W-1:0] CTRL_RESET = 2'b01;

    typedef enum logic [1:0] {
        UP        = 2'd0,
        DOWN_WAIT = 2'd1,
        DOWN      = 2'd2,
        UP_WAIT   = 2'd3
    } debounce_state_t;

endpackage

// File: rtl/avl_switch_accum_key_debounce.sv
// Synchronizes and debounces an active-low push button; pulses press_evt once per accepted press.
module key_debounce
    import avl_switch_accum_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press_evt
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic            key_s;
    debounce_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            press_d;

    assign key_s = sync_q[1];

    // Two-flop synchronizer, idles at released
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], key_n};
    end

    // The sample that leaves a stable state counts as the first of the run
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        case (state_q)
            UP: begin
                if (!key_s) begin
                    state_d = DOWN_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            DOWN_WAIT: begin
                if (key_s) begin
                    state_d = UP;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DOWN: begin
                if (key_s) begin
                    state_d = UP_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            UP_WAIT: begin
                if (!key_s) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = UP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = UP;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= UP;
            cnt_q     <= '0;
            press_evt <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_evt <= press_d;
        end
    end

endmodule

// File: rtl/avl_switch_accum.sv
// Avalon-MM accumulator peripheral: each debounced key press adds SW_IN to ACC.
module avl_switch_accum
    import avl_switch_accum_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned ACC_WIDTH       = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              AVL_CS,
    input  logic              AVL_READ,
    input  logic              AVL_WRITE,
    input  logic [ADDR_W-1:0] AVL_ADDR,
    input  logic [BE_W-1:0]   AVL_BYTE_EN,
    input  logic [DATA_W-1:0] AVL_WRITEDATA,
    output logic [DATA_W-1:0] AVL_READDATA,
    input  logic [SW_W-1:0]   SW_IN,
    input  logic              KEY_ACC_N,
    output logic [7:0]        LED_OUT,
    output logic              IRQ
);

    logic                 press_evt;
    logic [CTRL_W-1:0]    ctrl_q;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [STAT_W-1:0]    status_q;
    logic [COUNT_W-1:0]   count_q;

    logic                 wr_en, rd_en, wr_ctrl, wr_acc, wr_status;
    logic [DATA_W-1:0]    be_mask_c;
    logic [ACC_WIDTH-1:0] acc_wdata_c;
    logic [ACC_WIDTH:0]   sum_c;
    logic                 acc_add_c;
    logic [STAT_W-1:0]    status_set_c, status_clr_c, status_d;
    logic [DATA_W-1:0]    rdata_c;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk      (Clk),
        .rst      (Reset),
        .key_n    (KEY_ACC_N),
        .press_evt(press_evt)
    );

    assign wr_en     = AVL_CS & AVL_WRITE;
    assign rd_en     = AVL_CS & AVL_READ;
    assign wr_ctrl   = wr_en && (AVL_ADDR == ADDR_CTRL) && AVL_BYTE_EN[0];
    assign wr_acc    = wr_en && (AVL_ADDR == ADDR_ACC);
    assign wr_status = wr_en && (AVL_ADDR == ADDR_STATUS) && AVL_BYTE_EN[0];

    always_comb begin
        be_mask_c = '0;
        for (int b = 0; b < int'(BE_W); b++) be_mask_c[8*b +: 8] = {8{AVL_BYTE_EN[b]}};
    end

    assign acc_wdata_c = ACC_WIDTH'((DATA_W'(acc_q) & ~be_mask_c) | (AVL_WRITEDATA & be_mask_c));
    assign sum_c       = {1'b0, acc_q} + (ACC_WIDTH + 1)'(SW_IN);

    // A software ACC write in the press cycle suppresses the addition and its overflow
    assign acc_add_c = press_evt & ctrl_q[CTRL_ACC_EN] & ~wr_acc;

    always_comb begin
        status_set_c              = '0;
        status_set_c[STATUS_PEND] = press_evt;
        status_set_c[STATUS_OVF]  = acc_add_c & sum_c[ACC_WIDTH];
        status_clr_c              = wr_status ? AVL_WRITEDATA[STAT_W-1:0] : '0;
        status_d                  = (status_q & ~status_clr_c) | status_set_c;
    end

    always_comb begin
        rdata_c = '0;
        case (AVL_ADDR)
            ADDR_CTRL:   rdata_c = DATA_W'(ctrl_q);
            ADDR_ACC:    rdata_c = DATA_W'(acc_q);
            ADDR_STATUS: rdata_c = DATA_W'(status_q);
            ADDR_COUNT:  rdata_c = DATA_W'(count_q);
            default:     rdata_c = '0;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ctrl_q       <= CTRL_RESET;
            acc_q        <= '0;
            status_q     <= '0;
            count_q      <= '0;
            AVL_READDATA <= '0;
        end else begin
            if (wr_ctrl) ctrl_q <= AVL_WRITEDATA[CTRL_W-1:0];
            if (wr_acc)         acc_q <= acc_wdata_c;
            else if (acc_add_c) acc_q <= sum_c[ACC_WIDTH-1:0];
            status_q <= status_d;
            if (press_evt) count_q <= count_q + COUNT_W'(1);
            if (rd_en) AVL_READDATA <= rdata_c;
        end
    end

    assign LED_OUT = acc_q[7:0];
    assign IRQ     = status_q[STATUS_PEND] & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_avl_switch_accum.sv
// Self-checking bench for avl_switch_accum: table vectors, corner sequences and randomized presses.
module tb_avl_switch_accum;

    localparam int unsigned DEB   = 4;
    localparam int unsigned ACC_W = 16;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        AVL_CS, AVL_READ, AVL_WRITE;
    logic [1:0]  AVL_ADDR;
    logic [3:0]  AVL_BYTE_EN;
    logic [31:0] AVL_WRITEDATA;
    logic [31:0] AVL_READDATA;
    logic [7:0]  SW_IN;
    logic        KEY_ACC_N;
    logic [7:0]  LED_OUT;
    logic        IRQ;

    int checks   = 0;
    int failures = 0;

    logic [1:0]  m_ctrl;
    int unsigned m_acc;
    logic [1:0]  m_status;
    int unsigned m_count;

    avl_switch_accum #(
        .DEBOUNCE_CYCLES(DEB),
        .ACC_WIDTH      (ACC_W)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .AVL_CS       (AVL_CS),
        .AVL_READ     (AVL_READ),
        .AVL_WRITE    (AVL_WRITE),
        .AVL_ADDR     (AVL_ADDR),
        .AVL_BYTE_EN  (AVL_BYTE_EN),
        .AVL_WRITEDATA(AVL_WRITEDATA),
        .AVL_READDATA (AVL_READDATA),
        .SW_IN        (SW_IN),
        .KEY_ACC_N    (KEY_ACC_N),
        .LED_OUT      (LED_OUT),
        .IRQ          (IRQ)
    );

    always #5 Clk = ~Clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a; AVL_BYTE_EN = be; AVL_WRITEDATA = d;
        tick();
        AVL_CS = 1'b0; AVL_WRITE = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
        tick();
        AVL_CS = 1'b0; AVL_READ = 1'b0;
        d = AVL_READDATA;
    endtask

    task automatic check_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    // Reference model: register contents as the software-visible map describes them
    function automatic void model_reset();
        m_ctrl   = 2'b01;
        m_acc    = 0;
        m_status = 2'b00;
        m_count  = 0;
    endfunction

    function automatic void model_write(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] merged;
        case (a)
            2'd0: if (be[0]) m_ctrl = d[1:0];
            2'd1: begin
                merged = m_acc;
                for (int b = 0; b < 4; b++) if (be[b]) merged[8*b +: 8] = d[8*b +: 8];
                m_acc = merged % 65536;
            end
            2'd2: if (be[0]) m_status = m_status & ~d[1:0];
            default: ;
        endcase
    endfunction

    function automatic void model_press(input logic [7:0] sw, input bit acc_written);
        int unsigned s;
        m_count     = (m_count + 1) % 256;
        m_status[1] = 1'b1;
        if (m_ctrl[0] && !acc_written) begin
            s = m_acc + sw;
            if (s >= 65536) m_status[0] = 1'b1;
            m_acc = s % 65536;
        end
    endfunction

    task automatic check_model(input string tag);
        check_reg({tag, ".ctrl"},   2'd0, 32'(m_ctrl));
        check_reg({tag, ".acc"},    2'd1, m_acc);
        check_reg({tag, ".status"}, 2'd2, 32'(m_status));
        check_reg({tag, ".count"},  2'd3, m_count);
        check({tag, ".led"}, {24'b0, LED_OUT}, m_acc % 256);
        check({tag, ".irq"}, {31'b0, IRQ}, {31'b0, m_status[1] & m_ctrl[1]});
    endtask

    task automatic press(input logic [7:0] sw);
        SW_IN = sw;
        KEY_ACC_N = 1'b0;
        repeat (DEB + 6) tick();
        KEY_ACC_N = 1'b1;
        repeat (DEB + 6) tick();
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [1:0]  ctrl;
        bit          acc_wr;
        logic [15:0] acc_val;
        logic [7:0]  sw;
        logic [1:0]  w1c;
        logic [15:0] exp_acc;
        logic [7:0]  exp_count;
        logic [1:0]  exp_status;
        bit          exp_irq;
        logic [1:0]  exp_status2;
        bit          exp_irq2;
    } press_vec_t;

    rd_vec_t    rv[4];
    press_vec_t pv[6];

    initial begin
        rv[0] = '{2'd0, 32'h1};
        rv[1] = '{2'd1, 32'h0};
        rv[2] = '{2'd2, 32'h0};
        rv[3] = '{2'd3, 32'h0};
        //         ctrl  wr    acc_val   sw     w1c   acc       cnt    st     irq   st2    irq2
        pv[0] = '{2'd1, 1'b1, 16'hFFFE, 8'h03, 2'd1, 16'h0001, 8'd2, 2'd3, 1'b0, 2'd2, 1'b0};
        pv[1] = '{2'd2, 1'b0, 16'h0000, 8'h55, 2'd2, 16'h0001, 8'd3, 2'd2, 1'b1, 2'd0, 1'b0};
        pv[2] = '{2'd3, 1'b0, 16'h0000, 8'hFF, 2'd3, 16'h0100, 8'd4, 2'd2, 1'b1, 2'd0, 1'b0};
        pv[3] = '{2'd1, 1'b1, 16'hFF80, 8'h80, 2'd0, 16'h0000, 8'd5, 2'd3, 1'b0, 2'd3, 1'b0};
        pv[4] = '{2'd3, 1'b0, 16'h0000, 8'h01, 2'd1, 16'h0001, 8'd6, 2'd3, 1'b1, 2'd2, 1'b1};
        pv[5] = '{2'd1, 1'b0, 16'h0000, 8'h02, 2'd2, 16'h0003, 8'd7, 2'd2, 1'b0, 2'd0, 1'b0};

        Reset = 1'b1; AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
        AVL_ADDR = 2'd0; AVL_BYTE_EN = 4'h0; AVL_WRITEDATA = 32'h0;
        SW_IN = 8'h00; KEY_ACC_N = 1'b1;
        model_reset();
        repeat (2) tick();
        check("rst.readdata", AVL_READDATA, 32'h0);
        check("rst.led", {24'b0, LED_OUT}, 32'h0);
        check("rst.irq", {31'b0, IRQ}, 32'h0);
        Reset = 1'b0;
        tick();

        // Reset values through the bus
        foreach (rv[i]) check_reg($sformatf("reset_read[%0d]", i), rv[i].addr, rv[i].exp);

        // Bouncing press: short lows must not count; update lands 6 edges after first stable low
        SW_IN = 8'h05;
        for (int k = 0; k < 3; k++) begin
            KEY_ACC_N = 1'b0; repeat (2) tick();
            KEY_ACC_N = 1'b1; repeat (2) tick();
        end
        KEY_ACC_N = 1'b0;
        tick();
        repeat (5) tick();
        check("bounce.led_before", {24'b0, LED_OUT}, 32'h0);
        tick();
        check("bounce.led_at_edge6", {24'b0, LED_OUT}, 32'h5);
        repeat (4) tick();
        KEY_ACC_N = 1'b1;
        repeat (DEB + 6) tick();
        model_press(8'h05, 1'b0);
        check_model("bounce");

        // Table of single presses with known results
        foreach (pv[i]) begin
            bus_write(2'd0, 4'hF, 32'(pv[i].ctrl));
            model_write(2'd0, 4'hF, 32'(pv[i].ctrl));
            if (pv[i].acc_wr) begin
                bus_write(2'd1, 4'hF, 32'(pv[i].acc_val));
                model_write(2'd1, 4'hF, 32'(pv[i].acc_val));
            end
            press(pv[i].sw);
            model_press(pv[i].sw, 1'b0);
            check_reg($sformatf("vec[%0d].acc", i),    2'd1, 32'(pv[i].exp_acc));
            check_reg($sformatf("vec[%0d].count", i),  2'd3, 32'(pv[i].exp_count));
            check_reg($sformatf("vec[%0d].status", i), 2'd2, 32'(pv[i].exp_status));
            check($sformatf("vec[%0d].led", i), {24'b0, LED_OUT}, 32'(pv[i].exp_acc[7:0]));
            check($sformatf("vec[%0d].irq", i), {31'b0, IRQ}, {31'b0, pv[i].exp_irq});
            if (pv[i].w1c != 2'd0) begin
                bus_write(2'd2, 4'hF, 32'(pv[i].w1c));
                model_write(2'd2, 4'hF, 32'(pv[i].w1c));
            end
            check($sformatf("vec[%0d].irq_after", i), {31'b0, IRQ}, {31'b0, pv[i].exp_irq2});
            check_reg($sformatf("vec[%0d].status_after", i), 2'd2, 32'(pv[i].exp_status2));
        end

        // ACC write coincident with the press event: write wins, COUNT and pend still update
        SW_IN = 8'h10;
        KEY_ACC_N = 1'b0;
        tick();
        repeat (5) tick();
        bus_write(2'd1, 4'hF, 32'h1234);
        model_write(2'd1, 4'hF, 32'h1234);
        model_press(8'h10, 1'b1);
        repeat (4) tick();
        KEY_ACC_N = 1'b1;
        repeat (DEB + 6) tick();
        check_model("acc_wr_collide");
        check_reg("acc_wr_collide.acc_const", 2'd1, 32'h1234);

        // W1C coincident with the press event: pend set wins
        SW_IN = 8'h22;
        KEY_ACC_N = 1'b0;
        tick();
        repeat (5) tick();
        bus_write(2'd2, 4'hF, 32'h3);
        model_write(2'd2, 4'hF, 32'h3);
        model_press(8'h22, 1'b0);
        repeat (4) tick();
        KEY_ACC_N = 1'b1;
        repeat (DEB + 6) tick();
        check_reg("w1c_collide.status", 2'd2, 32'h2);
        check_model("w1c_collide");

        // 256 randomized presses with random register traffic; COUNT passes through the wrap
        for (int i = 0; i < 256; i++) begin
            int unsigned r;
            logic [31:0] d;
            logic [3:0]  be;
            r  = $urandom_range(0, 7);
            d  = $urandom;
            be = 4'($urandom_range(1, 15));
            case (r)
                0: begin bus_write(2'd0, 4'hF, 32'(d[1:0])); model_write(2'd0, 4'hF, 32'(d[1:0])); end
                1: begin bus_write(2'd1, be, d);             model_write(2'd1, be, d);             end
                2: begin bus_write(2'd2, 4'hF, 32'(d[1:0])); model_write(2'd2, 4'hF, 32'(d[1:0])); end
                3: begin bus_write(2'd3, 4'hF, d);           model_write(2'd3, 4'hF, d);           end
                default: ;
            endcase
            d = $urandom;
            press(d[7:0]);
            model_press(d[7:0], 1'b0);
            check_model($sformatf("rand[%0d]", i));
        end

        // Reset in DOWN_WAIT with the key held: one press after the debounce interval
        bus_write(2'd0, 4'hF, 32'h3);
        model_write(2'd0, 4'hF, 32'h3);
        check("pre_reset.irq", {31'b0, IRQ}, {31'b0, m_status[1]});
        SW_IN = 8'h07;
        KEY_ACC_N = 1'b0;
        repeat (3) tick();
        Reset = 1'b1;
        #1;
        check("reset_mid.led", {24'b0, LED_OUT}, 32'h0);
        check("reset_mid.irq", {31'b0, IRQ}, 32'h0);
        check("reset_mid.readdata", AVL_READDATA, 32'h0);
        model_reset();
        tick();
        tick();
        Reset = 1'b0;
        tick();
        repeat (5) tick();
        check("held_reset.led_before", {24'b0, LED_OUT}, 32'h0);
        tick();
        check("held_reset.led_at_edge6", {24'b0, LED_OUT}, 32'h7);
        repeat (20) tick();
        KEY_ACC_N = 1'b1;
        repeat (DEB + 6) tick();
        model_press(8'h07, 1'b0);
        check_model("held_reset");
        check_reg("held_reset.count_const", 2'd3, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/avl_switch_accum.md
# avl_switch_accum

Avalon-MM responder peripheral that replaces the separate switch, LED and accumulate-key PIOs on the Nios II system bus with one hardware accumulator. Each debounced press of the accumulate button adds SW_IN to a 16-bit accumulator. LED_OUT mirrors the accumulator's low byte. Software reads and writes the accumulator, control and status through four word registers, and can be interrupted on each press. The block sits in the FPGA fabric next to the SoC and connects through an exported Avalon-MM slave conduit plus one IRQ line.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples required to accept a press or release (10 ms at 50 MHz); range 2..2^20.
- ACC_WIDTH, 16, accumulator width; range 8..32.
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  asynchronous, active-high; all state returns to reset values immediately.
- AVL_CS  in  1  chip select; AVL_READ and AVL_WRITE are ignored when low.
- AVL_READ  in  1  read strobe.
- AVL_WRITE  in  1  write strobe.
- AVL_ADDR  in  2  word address.
- AVL_BYTE_EN  in  4  write byte enables.
- AVL_WRITEDATA  in  32  write data.
- AVL_READDATA  out  32  read data, fixed read latency of 1.
- SW_IN  in  8  slide switches, synchronous to Clk.
- KEY_ACC_N  in  1  accumulate button, active-low, asynchronous and bouncing.
- LED_OUT  out  8  acc[7:0].
- IRQ  out  1  level interrupt, equal to STATUS.pend AND CTRL.irq_en.

## Operation
- Register map:
  - 0 CTRL: bit0 acc_en, bit1 irq_en; R/W; reset 0x1.
  - 1 ACC: accumulator, zero-extended on read; R/W with byte enables; reset 0.
  - 2 STATUS: bit0 ovf (sticky), bit1 pend (sticky); write-1-to-clear using byte 0 only; reset 0.
  - 3 COUNT: bits 7:0 accepted presses, wraps 255->0; read-only, writes ignored; reset 0.
- Key path:
  - 2-FF synchronizer, reset to 1 (released).
  - Debounce FSM with states UP, DOWN_WAIT, DOWN, UP_WAIT.
  - UP -> DOWN_WAIT when the synchronized input is 0. A 1 returns to UP.
  - DOWN_WAIT -> DOWN after DEBOUNCE_CYCLES consecutive 0 samples. Entering DOWN pulses press_evt for one cycle.
  - DOWN -> UP_WAIT on a 1 sample. A 0 returns to DOWN.
  - UP_WAIT -> UP after DEBOUNCE_CYCLES consecutive 1 samples. No event on release.
  - The counter reloads on every state change.
- On press_evt:
  - COUNT increments and pend is set, regardless of acc_en.
  - If acc_en is set, ACC <= ACC + SW_IN, modulo 2^ACC_WIDTH.
  - ovf is set when the addition carries out of the top bit.
- Simultaneous events:
  - A software write to ACC in the same cycle as press_evt: the write wins, no addition occurs, ovf is unchanged, COUNT and pend still update.
  - W1C of pend or ovf in the same cycle as a new set: the set wins.
- A button held through reset deassertion produces exactly one press event after the debounce interval.
- Reads of undecoded bits return 0.

## Timing
- Read: AVL_READDATA is valid on the cycle after the CS+READ cycle, registered. AVL_READDATA is 0 at reset.
- Write: takes effect at the rising edge that samples CS+WRITE, so a read issued in the next cycle returns the new value.
- Press latency: with KEY_ACC_N first sampled low at edge E0 and held, ACC, COUNT, STATUS and LED_OUT update at edge E0+DEBOUNCE_CYCLES+2.
- IRQ is combinational from registered STATUS and CTRL and rises in the same cycle as pend.
- Reset values: LED_OUT=0, IRQ=0, AVL_READDATA=0, FSM=UP, debounce counter=0.

## Structure
- Package avl_switch_accum_pkg holds:
  - register address constants ADDR_CTRL, ADDR_ACC, ADDR_STATUS, ADDR_COUNT;
  - typedef debounce_state_t (UP, DOWN_WAIT, DOWN, UP_WAIT);
  - CTRL and STATUS bit-index constants.
- Sub-module key_debounce, parameterized by DEBOUNCE_CYCLES, contains the synchronizer, FSM and counter, and outputs press_evt. It is reused for KEY[0] debouncing elsewhere.
- The top module contains the register file, adder and read mux.

## Test plan
Bench uses DEBOUNCE_CYCLES=4 and ACC_WIDTH=16.
1. Reset, then read all four registers -> CTRL=0x1, ACC=0, STATUS=0, COUNT=0, LED_OUT=0, IRQ=0.
2. SW_IN=0x05; KEY_ACC_N low with 3 bounces of 2 cycles each, then stable low for 10 cycles, then released -> exactly one event: ACC=0x0005, COUNT=1, STATUS=0x2, LED_OUT=0x05. Update lands 6 edges after the first stable-low sample.
3. Write ACC=0xFFFE; SW_IN=0x03; one press -> ACC=0x0001, STATUS.ovf=1. W1C of STATUS=0x1 -> ovf=0, pend=1.
4. CTRL=0x2 (acc_en=0, irq_en=1); one press -> ACC unchanged, COUNT+1, IRQ=1. W1C of STATUS=0x2 -> IRQ=0 next cycle.
5. Force a write of ACC=0x1234 in the same cycle as press_evt, with SW_IN=0x10 -> ACC=0x1234, COUNT increments. Also run 256 presses -> COUNT wraps to 0.
6. Assert Reset mid-DOWN_WAIT while the key stays low -> all registers reset. After deassertion, exactly one press event fires after the debounce interval.
